rtc_calendar: RTL

Real-time date/time keeper that sits directly upstream of the UART date/time display stage and replaces its fixed string with live values. It counts seconds from the system clock and maintains a BCD calendar with leap-year handling for years 2000–2099. It accepts a time-set from the command path. A snapshot-then-read port serves the 20-character "DD.MM.YYYY HH:MM:SS\n" string one byte at a time to the transmit sequencer.

---
 rtl/rtc_pkg.sv | 76 +++++++
 rtl/rtc_calendar_if.sv | 40 ++++
 rtl/rtc_prescaler.sv | 38 +++
 rtl/rtc_calendar.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time calendar.
// Contents:
//   - ASCII constants.
//   - The reset date 01.01.2000 00:00:00.
//   - Field limits.
//   - BCD helpers: conversion, increment, days_in_month.
package rtc_pkg;

  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiDot   = 8'h2E;
  localparam logic [7:0] AsciiColon = 8'h3A;
  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiLf    = 8'h0A;

  // Binary upper limits of each field.
  localparam logic [6:0] SecMax   = 7'd59;
  localparam logic [6:0] MinMax   = 7'd59;
  localparam logic [6:0] HourMax  = 7'd23;
  localparam logic [6:0] MonthMax = 7'd12;
  localparam logic [6:0] YearMax  = 7'd99;

  // All fields are two BCD digits. Year is the 20xx suffix.
  typedef struct packed {
    logic [7:0] year;
    logic [7:0] month;
    logic [7:0] day;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_time_t;

  localparam rtc_time_t RstTime = '{
    year:  8'h00,
    month: 8'h01,
    day:   8'h01,
    hour:  8'h00,
    min:   8'h00,
    sec:   8'h00
  };

  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    return ({3'b000, bcd[7:4]} * 7'd10) + {3'b000, bcd[3:0]};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] bcd);
    return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
  endfunction

  // Adds one to a valid BCD byte. The caller handles field wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
    if (bcd[3:0] == 4'd9) begin
      return {bcd[7:4] + 4'd1, 4'd0};
    end
    return {bcd[7:4], bcd[3:0] + 4'd1};
  endfunction

  // Uses the year mod 4 leap rule, which is exact for 2000-2099.
  // Returns 0 for an out-of-range month.
  function automatic logic [4:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
    logic [6:0] m;
    logic [6:0] y;
    m = bcd_to_bin(month);
    y = bcd_to_bin(year);
    case (m)
      7'd1, 7'd3, 7'd5, 7'd7, 7'd8, 7'd10, 7'd12: return 5'd31;
      7'd4, 7'd6, 7'd9, 7'd11:                     return 5'd30;
      7'd2:                                        return ((y % 7'd4) == 7'd0) ? 5'd29 : 5'd28;
      default:                                     return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] nibble);
    return AsciiZero + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/rtc_calendar_if.sv
// Command, snapshot/read and live-field signals of the calendar.
// Signal groups:
//   - set_*: time-set request, with the set_err reject pulse.
//   - snap_req/rd_index/rd_char: snapshot-then-read string port.
//   - sec_pulse and sec..year: live BCD outputs.
// Modports:
//   - master: the command/transmit side.
//   - slave:  the calendar.
interface rtc_calendar_if;
  logic       set_valid;
  logic [7:0] set_sec;
  logic [7:0] set_min;
  logic [7:0] set_hour;
  logic [7:0] set_day;
  logic [7:0] set_month;
  logic [7:0] set_year;
  logic       set_err;
  logic       snap_req;
  logic [4:0] rd_index;
  logic [7:0] rd_char;
  logic       sec_pulse;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic [7:0] day;
  logic [7:0] month;
  logic [7:0] year;

  modport master (
    output set_valid, set_sec, set_min, set_hour, set_day, set_month, set_year,
    output snap_req, rd_index,
    input  set_err, rd_char, sec_pulse, sec, min, hour, day, month, year
  );

  modport slave (
    input  set_valid, set_sec, set_min, set_hour, set_day, set_month, set_year,
    input  snap_req, rd_index,
    output set_err, rd_char, sec_pulse, sec, min, hour, day, month, year
  );
endinterface

// File: rtl/rtc_prescaler.sv
// One-second prescaler.
// The counter runs 0..CLK_HZ-1 and wraps to 0.
// Ports:
//   - clk, reset: clock and active-low asynchronous reset.
//   - clear: synchronous restart to 0.
//   - tick: high on the terminal-count cycle.
module rtc_prescaler #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign tick = (cnt_q == CntW'(CLK_HZ - 1));

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_calendar.sv
// Real-time BCD calendar, 01.01.2000 to 31.12.2099.
// Ports:
//   - clk, reset: system clock and active-low asynchronous reset.
//   - bus (slave): time-set, snapshot/read, sec_pulse and the live fields.
// Behaviour:
//   - A valid set overrides a coincident tick and restarts the prescaler.
//   - snap_req copies the live fields into shadow registers.
//   - rd_char is a registered lookup of the "DD.MM.YYYY HH:MM:SS\n" shadow string.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input logic          clk,
  input logic          reset,
  rtc_calendar_if.slave bus
);

  logic      tick;
  logic      set_fields_ok;
  logic      set_ok;
  rtc_time_t set_time;
  rtc_time_t adv_time;
  rtc_time_t live_q, live_d;
  rtc_time_t shadow_q;
  logic      sec_pulse_q;
  logic      set_err_q;
  logic [7:0] rd_char_q, rd_char_d;

  assign set_time = '{
    year:  bus.set_year,
    month: bus.set_month,
    day:   bus.set_day,
    hour:  bus.set_hour,
    min:   bus.set_min,
    sec:   bus.set_sec
  };

  // Validate the set fields. The month range check also guarantees that days_in_month is non-zero.
  always_comb begin
    set_fields_ok = bcd_ok(set_time.sec) && bcd_ok(set_time.min) && bcd_ok(set_time.hour) &&
                    bcd_ok(set_time.day) && bcd_ok(set_time.month) && bcd_ok(set_time.year);
    set_fields_ok = set_fields_ok &&
                    (bcd_to_bin(set_time.sec) <= SecMax) &&
                    (bcd_to_bin(set_time.min) <= MinMax) &&
                    (bcd_to_bin(set_time.hour) <= HourMax) &&
                    (bcd_to_bin(set_time.month) >= 7'd1) &&
                    (bcd_to_bin(set_time.month) <= MonthMax) &&
                    (bcd_to_bin(set_time.year) <= YearMax) &&
                    (bcd_to_bin(set_time.day) >= 7'd1) &&
                    (bcd_to_bin(set_time.day) <=
                     {2'b00, days_in_month(set_time.month, set_time.year)});
  end

  assign set_ok = bus.set_valid && set_fields_ok;

  rtc_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(set_ok),
    .tick (tick)
  );

  // Carry chain: each field advances only when every lower field wraps.
  always_comb begin
    logic sec_wrap, min_wrap, hour_wrap, day_wrap, month_wrap;
    sec_wrap   = (live_q.sec == 8'h59);
    min_wrap   = (live_q.min == 8'h59);
    hour_wrap  = (live_q.hour == 8'h23);
    day_wrap   = (bcd_to_bin(live_q.day) == {2'b00, days_in_month(live_q.month, live_q.year)});
    month_wrap = (live_q.month == 8'h12);

    adv_time     = live_q;
    adv_time.sec = sec_wrap ? 8'h00 : bcd_inc(live_q.sec);
    if (sec_wrap) begin
      adv_time.min = min_wrap ? 8'h00 : bcd_inc(live_q.min);
    end
    if (sec_wrap && min_wrap) begin
      adv_time.hour = hour_wrap ? 8'h00 : bcd_inc(live_q.hour);
    end
    if (sec_wrap && min_wrap && hour_wrap) begin
      adv_time.day = day_wrap ? 8'h01 : bcd_inc(live_q.day);
    end
    if (sec_wrap && min_wrap && hour_wrap && day_wrap) begin
      adv_time.month = month_wrap ? 8'h01 : bcd_inc(live_q.month);
    end
    if (sec_wrap && min_wrap && hour_wrap && day_wrap && month_wrap) begin
      adv_time.year = (live_q.year == 8'h99) ? 8'h00 : bcd_inc(live_q.year);
    end
  end

  always_comb begin
    live_d = live_q;
    if (set_ok) begin
      live_d = set_time;
    end else if (tick) begin
      live_d = adv_time;
    end
  end

  always_comb begin
    rd_char_d = 8'h00;
    case (bus.rd_index)
      5'd0:    rd_char_d = ascii_digit(shadow_q.day[7:4]);
      5'd1:    rd_char_d = ascii_digit(shadow_q.day[3:0]);
      5'd2:    rd_char_d = AsciiDot;
      5'd3:    rd_char_d = ascii_digit(shadow_q.month[7:4]);
      5'd4:    rd_char_d = ascii_digit(shadow_q.month[3:0]);
      5'd5:    rd_char_d = AsciiDot;
      5'd6:    rd_char_d = ascii_digit(4'd2);
      5'd7:    rd_char_d = ascii_digit(4'd0);
      5'd8:    rd_char_d = ascii_digit(shadow_q.year[7:4]);
      5'd9:    rd_char_d = ascii_digit(shadow_q.year[3:0]);
      5'd10:   rd_char_d = AsciiSpace;
      5'd11:   rd_char_d = ascii_digit(shadow_q.hour[7:4]);
      5'd12:   rd_char_d = ascii_digit(shadow_q.hour[3:0]);
      5'd13:   rd_char_d = AsciiColon;
      5'd14:   rd_char_d = ascii_digit(shadow_q.min[7:4]);
      5'd15:   rd_char_d = ascii_digit(shadow_q.min[3:0]);
      5'd16:   rd_char_d = AsciiColon;
      5'd17:   rd_char_d = ascii_digit(shadow_q.sec[7:4]);
      5'd18:   rd_char_d = ascii_digit(shadow_q.sec[3:0]);
      5'd19:   rd_char_d = AsciiLf;
      default: rd_char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q      <= RstTime;
      shadow_q    <= RstTime;
      sec_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
      rd_char_q   <= 8'h00;
    end else begin
      live_q <= live_d;
      // Captures the pre-edge live value, even when a tick or set lands on the same edge.
      if (bus.snap_req) begin
        shadow_q <= live_q;
      end
      sec_pulse_q <= tick && !set_ok;
      set_err_q   <= bus.set_valid && !set_fields_ok;
      rd_char_q   <= rd_char_d;
    end
  end

  assign bus.sec       = live_q.sec;
  assign bus.min       = live_q.min;
  assign bus.hour      = live_q.hour;
  assign bus.day       = live_q.day;
  assign bus.month     = live_q.month;
  assign bus.year      = live_q.year;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.set_err   = set_err_q;
  assign bus.rd_char   = rd_char_q;

endmodule
